// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Function : Fetch-stage control FSM. Sequences instruction-memory requests,
//            drives the PC-source select and PC load enable, holds the PC
//            while downstream stalls, counts taken redirects (saturating)
//            and flags an instruction-memory timeout (sticky until reset).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15,  // max REQ cycles without ack before ERR (>=1)
  parameter int CNT_W       = 16   // redirect counter width (>=2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             is_bne,
  input  logic             zero,
  output logic             imem_req,
  output logic             instr_valid,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] redirect_count,
  output logic             timeout_err
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // PC-source select encodings (contMux4).
  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_JAL  = 2'b01;
  localparam logic [1:0] SEL_BNE  = 2'b10;
  localparam logic [1:0] SEL_JALR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_EXEC = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        redirect_sel;
  logic              redirect;

  // Redirect target by priority: JALR over JAL over taken BNE.
  always_comb begin
    redirect_sel = SEL_PC4;
    if (is_jalr)
      redirect_sel = SEL_JALR;
    else if (is_jal)
      redirect_sel = SEL_JAL;
    else if (is_bne && !zero)
      redirect_sel = SEL_BNE;
  end

  // PC loads when an instruction in EXEC/HOLD is accepted; select only meaningful then.
  always_comb begin
    pc_we    = ((state == S_EXEC) || (state == S_HOLD)) && !stall;
    pc_sel   = pc_we ? redirect_sel : SEL_PC4;
    redirect = pc_we && (pc_sel != SEL_PC4);
  end

  // Main FSM; state-decoded outputs are registered together with the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state       <= S_REQ;
          wait_cnt    <= '0;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        S_REQ: begin
          if (imem_ack) begin
            state       <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= S_ERR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC, S_HOLD: begin
          if (stall) begin
            state       <= S_HOLD;
            instr_valid <= 1'b1;
          end else begin
            state       <= S_REQ;
            wait_cnt    <= '0;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        S_ERR: begin
          // Terminal until reset.
          state       <= S_ERR;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          timeout_err <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          wait_cnt    <= '0;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          timeout_err <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of taken redirects.
  always_ff @(posedge clock) begin
    if (reset)
      redirect_count <= '0;
    else if (redirect && (redirect_count != {CNT_W{1'b1}}))
      redirect_count <= redirect_count + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_sequencer
// Function : Directed self-checking bench for fetch_sequencer. Instance "a"
//            uses default parameters, instance "b" uses MEM_TIMEOUT=4, CNT_W=2.
//            Both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic imem_ack = 1'b0;
  logic stall = 1'b0;
  logic is_jal = 1'b0;
  logic is_jalr = 1'b0;
  logic is_bne = 1'b0;
  logic zero = 1'b0;

  logic        imem_req_a, instr_valid_a, pc_we_a, timeout_err_a;
  logic [1:0]  pc_sel_a;
  logic [15:0] count_a;
  logic        imem_req_b, instr_valid_b, pc_we_b, timeout_err_b;
  logic [1:0]  pc_sel_b;
  logic [1:0]  count_b;

  // {imem_req, instr_valid, pc_we, pc_sel}
  logic [4:0] vec_a, vec_b;
  assign vec_a = {imem_req_a, instr_valid_a, pc_we_a, pc_sel_a};
  assign vec_b = {imem_req_b, instr_valid_b, pc_we_b, pc_sel_b};

  int checks = 0;
  int failures = 0;

  fetch_sequencer dut_a (
    .clock(clock), .reset(reset), .imem_ack(imem_ack), .stall(stall),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_bne(is_bne), .zero(zero),
    .imem_req(imem_req_a), .instr_valid(instr_valid_a), .pc_we(pc_we_a),
    .pc_sel(pc_sel_a), .redirect_count(count_a), .timeout_err(timeout_err_a)
  );

  fetch_sequencer #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .imem_ack(imem_ack), .stall(stall),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_bne(is_bne), .zero(zero),
    .imem_req(imem_req_b), .instr_valid(instr_valid_b), .pc_we(pc_we_b),
    .pc_sel(pc_sel_b), .redirect_count(count_b), .timeout_err(timeout_err_b)
  );

  always #5 clock = ~clock;

  // Apply one cycle's inputs at the falling edge, then settle before checks.
  task automatic drive(input logic r, input logic ack, input logic st,
                       input logic jal, input logic jalr, input logic bne,
                       input logic z);
    @(negedge clock);
    reset = r; imem_ack = ack; stall = st;
    is_jal = jal; is_jalr = jalr; is_bne = bne; zero = z;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 1, 0);
    checks++;
    if (vec_a !== 5'b00000 || timeout_err_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs_a actual=%b/%b required=00000/0", vec_a, timeout_err_a);
    end
    checks++;
    if (count_a !== 16'd0 || count_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_count actual=%0d/%0d required=0/0", count_a, count_b);
    end
  endtask

  // T1: plain sequence IDLE,REQ,EXEC,REQ,EXEC,...
  task automatic test_sequence();
    logic [4:0] exp;
    for (int c = 1; c <= 7; c++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      if (c == 1)          exp = 5'b00000;
      else if (c % 2 == 0) exp = 5'b10000;
      else                 exp = 5'b01100;
      checks++;
      if (vec_a !== exp) begin
        failures++;
        $display("FAIL seq_cycle%0d actual=%b required=%b", c, vec_a, exp);
      end
    end
  endtask

  // T2: BNE taken / not taken.
  task automatic test_bne();
    drive(0, 1, 0, 0, 0, 1, 0);  // REQ: flags ignored
    checks++;
    if (vec_a !== 5'b10000 || count_a !== 16'd0) begin
      failures++;
      $display("FAIL bne_req actual=%b cnt=%0d required=10000 cnt=0", vec_a, count_a);
    end
    drive(0, 1, 0, 0, 0, 1, 0);  // EXEC: taken
    checks++;
    if (vec_a !== 5'b01110) begin
      failures++;
      $display("FAIL bne_taken actual=%b required=01110", vec_a);
    end
    drive(0, 1, 0, 0, 0, 1, 1);  // REQ
    checks++;
    if (count_a !== 16'd1) begin
      failures++;
      $display("FAIL bne_count actual=%0d required=1", count_a);
    end
    drive(0, 1, 0, 0, 0, 1, 1);  // EXEC: not taken
    checks++;
    if (vec_a !== 5'b01100) begin
      failures++;
      $display("FAIL bne_not_taken actual=%b required=01100", vec_a);
    end
    drive(0, 1, 0, 0, 0, 0, 0);  // REQ
    checks++;
    if (count_a !== 16'd1) begin
      failures++;
      $display("FAIL bne_count_hold actual=%0d required=1", count_a);
    end
  endtask

  // T3: simultaneous decode flags.
  task automatic test_priority();
    drive(0, 1, 0, 1, 0, 1, 0);  // EXEC: JAL beats BNE
    checks++;
    if (vec_a !== 5'b01101) begin
      failures++;
      $display("FAIL prio_jal_bne actual=%b required=01101", vec_a);
    end
    drive(0, 1, 0, 0, 0, 0, 0);  // REQ
    checks++;
    if (count_a !== 16'd2) begin
      failures++;
      $display("FAIL prio_count1 actual=%0d required=2", count_a);
    end
    drive(0, 1, 0, 1, 1, 0, 0);  // EXEC: JALR beats JAL
    checks++;
    if (vec_a !== 5'b01111) begin
      failures++;
      $display("FAIL prio_jalr_jal actual=%b required=01111", vec_a);
    end
    drive(0, 1, 0, 0, 0, 0, 0);  // REQ
    checks++;
    if (count_a !== 16'd3) begin
      failures++;
      $display("FAIL prio_count2 actual=%0d required=3", count_a);
    end
  endtask

  // T4: three stall cycles from EXEC, then release.
  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      checks++;
      if (vec_a !== 5'b01000) begin
        failures++;
        $display("FAIL stall_cycle%0d actual=%b required=01000", c, vec_a);
      end
    end
    drive(0, 1, 0, 1, 0, 0, 0);  // release
    checks++;
    if (vec_a !== 5'b01101) begin
      failures++;
      $display("FAIL stall_release actual=%b required=01101", vec_a);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (vec_a !== 5'b10000 || count_a !== 16'd4) begin
      failures++;
      $display("FAIL stall_after actual=%b cnt=%0d required=10000 cnt=4", vec_a, count_a);
    end
  endtask

  // T5: memory timeout on instance b (MEM_TIMEOUT=4).
  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);  // IDLE
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (vec_b !== 5'b10000 || timeout_err_b !== 1'b0) begin
        failures++;
        $display("FAIL timeout_req%0d actual=%b/%b required=10000/0", c, vec_b, timeout_err_b);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (vec_b !== 5'b00000 || timeout_err_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err actual=%b/%b required=00000/1", vec_b, timeout_err_b);
    end
    checks++;
    if (vec_a !== 5'b10000 || timeout_err_a !== 1'b0) begin
      failures++;
      $display("FAIL timeout_default_waits actual=%b/%b required=10000/0", vec_a, timeout_err_a);
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 1, 0, 0, 0);  // late ack ignored
      checks++;
      if (vec_b !== 5'b00000 || timeout_err_b !== 1'b1) begin
        failures++;
        $display("FAIL timeout_sticky%0d actual=%b/%b required=00000/1", c, vec_b, timeout_err_b);
      end
    end
  endtask

  // T6: reset while in HOLD, then counter saturation on instance b.
  task automatic test_reset_hold_saturate();
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 3, 3};
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);  // IDLE
    drive(0, 1, 0, 0, 0, 0, 0);  // REQ
    drive(0, 1, 1, 1, 0, 0, 0);  // EXEC, stall
    drive(0, 1, 1, 1, 0, 0, 0);  // HOLD
    checks++;
    if (vec_a !== 5'b01000) begin
      failures++;
      $display("FAIL hold_before_reset actual=%b required=01000", vec_a);
    end
    drive(1, 1, 1, 1, 0, 0, 0);  // reset asserted during HOLD
    drive(0, 1, 0, 1, 0, 0, 0);  // IDLE after reset
    checks++;
    if (vec_a !== 5'b00000 || count_a !== 16'd0 || timeout_err_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_hold actual=%b cnt=%0d terr_b=%b required=00000 cnt=0 terr_b=0",
               vec_a, count_a, timeout_err_b);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 1, 0, 0, 0);  // REQ
      if (k > 0) begin
        checks++;
        if (count_b !== 2'(exp_cnt[k-1])) begin
          failures++;
          $display("FAIL sat_count%0d actual=%0d required=%0d", k - 1, count_b, exp_cnt[k-1]);
        end
      end
      drive(0, 1, 0, 1, 0, 0, 0);  // EXEC with JAL
      checks++;
      if (vec_b !== 5'b01101) begin
        failures++;
        $display("FAIL sat_jal%0d actual=%b required=01101", k, vec_b);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (count_b !== 2'(exp_cnt[4])) begin
      failures++;
      $display("FAIL sat_count4 actual=%0d required=%0d", count_b, exp_cnt[4]);
    end
    checks++;
    if (count_a !== 16'd5) begin
      failures++;
      $display("FAIL wide_count actual=%0d required=5", count_a);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bne();
    test_priority();
    test_stall();
    test_timeout();
    test_reset_hold_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
